// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_ctrl_pkg
// Shared definitions for the digit-serial subtract controller:
//   - FSM state encoding (the unused code 2'b11 recovers to IDLE)
//   - digit width of the shared subtract slice
//   - width helper for the digit counter
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  // Bits consumed per RUN cycle by the shared slice.
  localparam int DIGIT = 2;

  // clog2(n) with a floor of 1, so a single-digit operand still gets a
  // one-bit counter.
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_sub2_slice.sv
// sub2_slice
// Combinational 2-bit subtract-with-borrow slice: {COUT,O} = I0 + ~I1 + ~CIN.
// Subtraction is done as addition of the one's complement, so COUT is a
// not-borrow and CIN is a borrow (active high).
// Ports:
//   I0   in  2 : minuend digit
//   I1   in  2 : subtrahend digit
//   CIN  in  1 : borrow-in, active high
//   O    out 2 : difference digit
//   COUT out 1 : carry-out, i.e. NOT borrow-out
module sub2_slice
  import serial_sub_ctrl_pkg::*;
(
  input  logic [1:0] I0,
  input  logic [1:0] I1,
  input  logic       CIN,
  output logic [1:0] O,
  output logic       COUT
);

  logic [2:0] sum;

  assign sum  = {1'b0, I0} + {1'b0, ~I1} + {2'b00, ~CIN};
  assign O    = sum[1:0];
  assign COUT = sum[2];

endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Digit-serial subtractor: computes (A - B - BIN) mod 2^W by running one
// shared 2-bit subtract slice over W/2 cycles, LSB digit first.
// Ports:
//   CLKIN  in  1 : clock, rising edge
//   RESETN in  1 : asynchronous active-low reset
//   START  in  1 : request, accepted only in IDLE
//   A, B   in  W : operands, sampled on the accepting edge
//   BIN    in  1 : borrow-in, sampled on the accepting edge
//   BUSY   out 1 : high while digits are being processed
//   DONE   out 1 : one-cycle pulse when D/BOUT/ZERO are updated
//   D      out W : difference
//   BOUT   out 1 : borrow-out (A < B + BIN)
//   ZERO   out 1 : D == 0
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for START; operands loaded on accept
// RUN   | one digit per cycle through the shared slice
// FIN   | DONE pulse, results already registered
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLKIN,
  input  logic         RESETN,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         BIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] D,
  output logic         BOUT,
  output logic         ZERO
);

  localparam int CW = cnt_width(W / DIGIT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W / DIGIT - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  ra_q, ra_d;
  logic [W-1:0]  rb_q, rb_d;
  logic [W-1:0]  rd_q, rd_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  d_q, d_d;
  logic          bout_q, bout_d;
  logic          zero_q, zero_d;

  logic [1:0]    slice_sum;
  logic          slice_co;
  logic [W-1:0]  sum_top;
  logic [W-1:0]  rd_next;

  sub2_slice u_slice (
    .I0   (ra_q[1:0]),
    .I1   (rb_q[1:0]),
    .CIN  (br_q),
    .O    (slice_sum),
    .COUT (slice_co)
  );

  // New digit enters at the MSB end while the result shifts right, so after
  // W/2 digits the LSB digit has arrived at bit 0. Written as a shift/OR so
  // it stays valid for W=2.
  assign sum_top = W'(slice_sum) << (W - DIGIT);
  assign rd_next = sum_top | (rd_q >> DIGIT);

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          ra_d    = A;
          rb_d    = B;
          br_d    = BIN;
          cnt_d   = CNT_LOAD;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        ra_d  = ra_q >> DIGIT;
        rb_d  = rb_q >> DIGIT;
        rd_d  = rd_next;
        br_d  = ~slice_co;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          d_d     = rd_next;
          bout_d  = ~slice_co;
          zero_d  = (rd_next == '0);
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded straight from the state flops; no input reaches an output
  // without passing through a register.
  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_FIN);
  assign D    = d_q;
  assign BOUT = bout_q;
  assign ZERO = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n, start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8, zero8;
  logic [7:0] d8;

  logic       rst2_n, start2, bin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, bout2, zero2;
  logic [1:0] d2;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub_ctrl #(.W(8)) u_dut8 (
    .CLKIN(clk), .RESETN(rst8_n), .START(start8), .A(a8), .B(b8), .BIN(bin8),
    .BUSY(busy8), .DONE(done8), .D(d8), .BOUT(bout8), .ZERO(zero8)
  );

  serial_sub_ctrl #(.W(2)) u_dut2 (
    .CLKIN(clk), .RESETN(rst2_n), .START(start2), .A(a2), .B(b2), .BIN(bin2),
    .BUSY(busy2), .DONE(done2), .D(d2), .BOUT(bout2), .ZERO(zero2)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Issues one W=8 operation and reports what was observed; latency counts
  // cycles after the accepting edge (-1 if DONE never came).
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output int lat, output int busy_cnt,
                         output logic [7:0] d, output logic bout, output logic zero);
    lat = -1; busy_cnt = 0; d = 8'h00; bout = 1'b0; zero = 1'b0;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        lat = c; d = d8; bout = bout8; zero = zero8;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst8_n = 1'b0; rst2_n = 1'b0;
    start8 = 1'b0; start2 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    a2 = 2'b00; b2 = 2'b00; bin2 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if ({busy8, done8, bout8, zero8} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags8: got %b expected 0000", {busy8, done8, bout8, zero8});
    end
    n_tests++; if (d8 !== 8'h00) begin
      n_fail++; $display("FAIL reset_d8: got %h expected 00", d8);
    end
    n_tests++; if ({busy2, done2, bout2, zero2, d2} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_w2: got %b expected 000000", {busy2, done2, bout2, zero2, d2});
    end
    rst8_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc; logic [7:0] d; logic bo, z;
    run_op8(8'h5A, 8'h3C, 1'b0, lat, bc, d, bo, z);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    n_tests++; if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
    n_tests++; if (d !== 8'h1E) begin n_fail++; $display("FAIL basic_d: got %h expected 1e", d); end
    n_tests++; if (bo !== 1'b0) begin n_fail++; $display("FAIL basic_bout: got %b expected 0", bo); end
    n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL basic_zero: got %b expected 0", z); end
    n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done8); end
    n_tests++; if (d8 !== 8'h1E) begin n_fail++; $display("FAIL basic_d_hold: got %h expected 1e", d8); end
  endtask

  task automatic test_borrow();
    int lat, bc; logic [7:0] d; logic bo, z;
    run_op8(8'h00, 8'h01, 1'b0, lat, bc, d, bo, z);
    n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL borrow1_d: got %h expected ff", d); end
    n_tests++; if (bo !== 1'b1) begin n_fail++; $display("FAIL borrow1_bout: got %b expected 1", bo); end
    run_op8(8'h00, 8'h00, 1'b1, lat, bc, d, bo, z);
    n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL borrow2_d: got %h expected ff", d); end
    n_tests++; if (bo !== 1'b1) begin n_fail++; $display("FAIL borrow2_bout: got %b expected 1", bo); end
    n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL borrow2_zero: got %b expected 0", z); end
  endtask

  task automatic test_zero();
    int lat, bc; logic [7:0] d; logic bo, z;
    run_op8(8'h10, 8'h0F, 1'b1, lat, bc, d, bo, z);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL zero_d: got %h expected 00", d); end
    n_tests++; if (bo !== 1'b0) begin n_fail++; $display("FAIL zero_bout: got %b expected 0", bo); end
    n_tests++; if (z !== 1'b1) begin n_fail++; $display("FAIL zero_flag: got %b expected 1", z); end
  endtask

  task automatic test_ignore_start();
    int done_cnt; logic [7:0] first_d;
    done_cnt = 0; first_d = 8'h00;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (done8) begin
        done_cnt++;
        if (done_cnt == 1) first_d = d8;
      end
      start8 = (c == 2);
      if (c == 2) begin a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; end
    end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    n_tests++; if (first_d !== 8'h22) begin n_fail++; $display("FAIL ignore_first_d: got %h expected 22", first_d); end
    n_tests++; if (d8 !== 8'h22) begin n_fail++; $display("FAIL ignore_d_hold: got %h expected 22", d8); end
  endtask

  task automatic test_reset_mid_run();
    int dcnt, lat, bc; logic [7:0] d; logic bo, z;
    dcnt = 0;
    @(negedge clk);
    a8 = 8'h44; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst8_n = 1'b0;
    #1;
    n_tests++; if ({busy8, done8, bout8, zero8, d8} !== 12'h000) begin
      n_fail++; $display("FAIL midrst_outputs: got %h expected 000", {busy8, done8, bout8, zero8, d8});
    end
    @(negedge clk);
    rst8_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    n_tests++; if (dcnt !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", dcnt); end
    run_op8(8'hFF, 8'h80, 1'b0, lat, bc, d, bo, z);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 5", lat); end
    n_tests++; if (d !== 8'h7F) begin n_fail++; $display("FAIL midrst_d: got %h expected 7f", d); end
    n_tests++; if (bo !== 1'b0) begin n_fail++; $display("FAIL midrst_bout: got %b expected 0", bo); end
  endtask

  task automatic test_back_to_back();
    int prev, dcount;
    prev = -1; dcount = 0;
    @(negedge clk);
    a2 = 2'b01; b2 = 2'b10; bin2 = 1'b0; start2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done2) begin
        dcount++;
        n_tests++; if (d2 !== 2'b11) begin n_fail++; $display("FAIL b2b_d: got %b expected 11", d2); end
        n_tests++; if (bout2 !== 1'b1) begin n_fail++; $display("FAIL b2b_bout: got %b expected 1", bout2); end
        if (prev >= 0) begin
          n_tests++; if (c - prev !== 3) begin n_fail++; $display("FAIL b2b_period: got %0d expected 3", c - prev); end
        end
        prev = c;
      end
    end
    start2 = 1'b0;
    n_tests++; if (dcount !== 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 4", dcount); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
